// File: rtl/idct_mac_accum.sv
// idct_mac_accum
//   Multiply-accumulate back end of an IDCT row/column engine. Signed 32-bit
//   products from the upstream multiplier are summed TAPS at a time. Each sum
//   is rounded half-up, shifted right by SHIFT and saturated to OP_BITWIDTH
//   bits. The result is then queued in a 2-entry output FIFO, framed into rows
//   of 8 samples and blocks of 64 samples.
//
// Ports
//   clk        single clock, rising edge
//   rstN       asynchronous reset, active-low
//   state      controller phase: 010/011/100 compute, 000 abort/idle
//   P          signed product from the multiplier wrapper
//   p_valid    P valid this cycle
//   p_ready    product accepted when p_valid && p_ready
//   out_data   rounded, saturated sample at the FIFO head (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts out_data
//   out_last   head entry is the 8th sample of a row
//   blk_done   one-cycle pulse after the 64th sample of a block is popped
//   sat_flag   sticky saturation indicator
//   sat_clr    synchronous clear of sat_flag (a simultaneous set wins)
module idct_mac_accum #(
  parameter int OP_BITWIDTH = 16,
  parameter int TAPS        = 8,
  parameter int SHIFT       = 8
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [2:0]                    state,
  input  logic signed [31:0]            P,
  input  logic                          p_valid,
  output logic                          p_ready,
  output logic signed [OP_BITWIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          blk_done,
  output logic                          sat_flag,
  input  logic                          sat_clr
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int ACC_W = 32 + TAP_W;
  // One guard bit so that adding the rounding constant cannot overflow.
  localparam int RND_W = ACC_W + 1;

  localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(2 ** (SHIFT - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX  =
    {{(RND_W - OP_BITWIDTH + 1){1'b0}}, {(OP_BITWIDTH - 1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN  =
    {{(RND_W - OP_BITWIDTH + 1){1'b1}}, {(OP_BITWIDTH - 1){1'b0}}};

  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [RND_W-1:0] t;
    t = {a[ACC_W-1], a};
    t = t + RND_HALF;
    return t >>> SHIFT;
  endfunction

  function automatic logic sat_hit(input logic signed [RND_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OP_BITWIDTH-1:0] saturate(
    input logic signed [RND_W-1:0] v
  );
    if (v > SAT_MAX)
      return {1'b0, {(OP_BITWIDTH - 1){1'b1}}};
    else if (v < SAT_MIN)
      return {1'b1, {(OP_BITWIDTH - 1){1'b0}}};
    else
      return v[OP_BITWIDTH-1:0];
  endfunction

  logic                          idle_phase;
  logic                          compute_phase;
  logic                          accept;
  logic                          push;
  logic                          pop;

  logic [TAP_W-1:0]              tap_cnt;
  logic signed [ACC_W-1:0]       acc_p0;
  logic signed [ACC_W-1:0]       p_ext;
  logic signed [ACC_W-1:0]       sum_p0;
  logic signed [RND_W-1:0]       rnd_p0;
  logic signed [OP_BITWIDTH-1:0] res_p0;
  logic                          sat_p0;

  logic signed [OP_BITWIDTH-1:0] fifo_data [2];
  logic                          fifo_last [2];
  logic                          wr_ptr;
  logic                          rd_ptr;
  logic [1:0]                    fifo_cnt;
  logic [2:0]                    row_cnt;
  logic [5:0]                    blk_cnt;

  assign idle_phase    = (state == 3'b000);
  assign compute_phase = (state == 3'b010) || (state == 3'b011) ||
                         (state == 3'b100);

  // A full FIFO can still take a product when the head leaves this cycle;
  // this is the only combinational use of out_ready.
  assign p_ready = (fifo_cnt < 2'd2) || out_ready;
  assign accept  = p_valid && p_ready && compute_phase;
  assign push    = accept && (tap_cnt == LAST_TAP);
  assign pop     = out_valid && out_ready;

  // Stage p0: accumulate; the final tap's sum is rounded and saturated
  // straight from the adder output so it can be written in the same edge.
  always_comb begin
    p_ext  = {{TAP_W{P[31]}}, P};
    sum_p0 = (tap_cnt == '0) ? p_ext : acc_p0 + p_ext;
    rnd_p0 = round_shift(sum_p0);
    res_p0 = saturate(rnd_p0);
    sat_p0 = sat_hit(rnd_p0);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tap_cnt <= '0;
      acc_p0  <= '0;
    end else if (idle_phase) begin
      tap_cnt <= '0;
      acc_p0  <= '0;
    end else if (accept) begin
      tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + TAP_W'(1);
      acc_p0  <= sum_p0;
    end
  end

  // Stage p1: output FIFO. Storage is plain data; the empty-gating of
  // out_data/out_last keeps the outputs defined while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= res_p0;
      fifo_last[wr_ptr] <= (row_cnt == 3'd7);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  // Framing: row position travels with each pushed sample, block position
  // advances on pops. Both restart when the controller aborts.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      row_cnt  <= 3'd0;
      blk_cnt  <= 6'd0;
      blk_done <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (idle_phase)
        row_cnt <= 3'd0;
      else if (push)
        row_cnt <= row_cnt + 3'd1;

      if (idle_phase)
        blk_cnt <= 6'd0;
      else if (pop)
        blk_cnt <= blk_cnt + 6'd1;

      // Registered so that out_ready never reaches blk_done combinationally.
      blk_done <= pop && (blk_cnt == 6'd63);

      if (push && sat_p0)
        sat_flag <= 1'b1;
      else if (sat_clr)
        sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idct_mac_accum.sv
module tb_idct_mac_accum;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  state;
  logic [31:0] P;
  logic        p_valid;
  logic        p_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        blk_done;
  logic        sat_flag;
  logic        sat_clr;

  idct_mac_accum #(.OP_BITWIDTH(16), .TAPS(8), .SHIFT(8)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .state     (state),
    .P         (P),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .blk_done  (blk_done),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  // Reference model: queue of finished samples, the products of the row in
  // progress, and plain counters for row/block position.
  typedef struct {
    logic [15:0] d;
    logic        l;
  } ent_t;

  ent_t mq[$];
  int   row_q[$];
  int   m_row;
  int   m_blk;
  logic m_blk_done;
  logic m_sat;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop_obs, n_last_obs, n_blk_obs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    row_q.delete();
    m_row      = 0;
    m_blk      = 0;
    m_blk_done = 1'b0;
    m_sat      = 1'b0;
  endtask

  // One clock cycle: drive, check DUT against model, advance model.
  task automatic cycle(input logic [2:0] st, input logic pv, input logic [31:0] p,
                       input logic ordy, input logic sclr, output bit accd);
    bit          mrdy, mpop, macc, nbd, sset;
    longint      s, v;
    logic [15:0] d, hd;
    logic        hl;
    state = st; p_valid = pv; P = p; out_ready = ordy; sat_clr = sclr;
    #3;
    mrdy = (mq.size() < 2) || ordy;
    hd = 16'h0; hl = 1'b0;
    if (mq.size() > 0) begin hd = mq[0].d; hl = mq[0].l; end
    chk("p_ready",   64'(p_ready),   64'(mrdy));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("out_data",  64'(out_data),  64'(hd));
    chk("out_last",  64'(out_last),  64'(hl));
    chk("blk_done",  64'(blk_done),  64'(m_blk_done));
    chk("sat_flag",  64'(sat_flag),  64'(m_sat));
    if (out_valid && ordy) n_pop_obs++;
    if (out_valid && ordy && out_last) n_last_obs++;
    if (blk_done) n_blk_obs++;

    mpop = (mq.size() > 0) && ordy;
    macc = pv && mrdy && (st == 3'b010 || st == 3'b011 || st == 3'b100);
    nbd  = 1'b0;
    sset = 1'b0;
    if (mpop) begin
      void'(mq.pop_front());
      nbd   = (m_blk == 63);
      m_blk = (m_blk + 1) % 64;
    end
    if (st == 3'b000) begin
      row_q.delete();
      m_row = 0;
      m_blk = 0;
    end else if (macc) begin
      row_q.push_back(int'(p));
      if (row_q.size() == 8) begin
        s = 0;
        foreach (row_q[i]) s += longint'(row_q[i]);
        v = (s + 128) >>> 8;
        if (v > 32767) begin v = 32767; sset = 1'b1; end
        else if (v < -32768) begin v = -32768; sset = 1'b1; end
        d = v[15:0];
        mq.push_back('{d: d, l: (m_row == 7)});
        m_row = (m_row + 1) % 8;
        row_q.delete();
      end
    end
    m_sat      = sset ? 1'b1 : (sclr ? 1'b0 : m_sat);
    m_blk_done = nbd;
    accd = macc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstN = 1'b0; p_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0; state = 3'b000;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last",  64'(out_last),  64'(0));
    chk("rst_blk_done",  64'(blk_done),  64'(0));
    chk("rst_sat_flag",  64'(sat_flag),  64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_p_ready",   64'(p_ready),   64'(1));
    model_clear();
    @(posedge clk);
    #2;
    rstN = 1'b1;
  endtask

  task automatic send(input logic [2:0] st, input logic [31:0] p, input logic ordy,
                      input logic sclr);
    bit a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 50) begin
      cycle(st, 1'b1, p, ordy, sclr, a);
      tries++;
    end
    if (!a) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic feed_row(input logic [2:0] st, input logic [31:0] base,
                          input logic [31:0] lastv, input logic ordy);
    for (int i = 0; i < 7; i++) send(st, base, ordy, 1'b0);
    send(st, lastv, ordy, 1'b0);
  endtask

  task automatic idle(input int n, input logic [2:0] st, input logic ordy);
    bit a;
    for (int i = 0; i < n; i++) cycle(st, 1'b0, 32'h0, ordy, 1'b0, a);
  endtask

  function automatic logic [2:0] rnd_st();
    case ($urandom % 3)
      0:       return 3'b010;
      1:       return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [31:0] rnd_p();
    int v;
    case ($urandom % 4)
      0:       v = int'($urandom);
      1:       v = int'($urandom_range(2000)) - 1000;
      2:       v = int'(32'h7FFF0000 ^ ($urandom & 32'h0000FFFF));
      default: v = -int'($urandom_range(100000));
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    rstN = 1'b0; state = 3'b000; P = 32'h0; p_valid = 1'b0;
    out_ready = 1'b0; sat_clr = 1'b0;
    n_pop_obs = 0; n_last_obs = 0; n_blk_obs = 0;
    #2;
    do_reset();

    // Basic row: 8 x 256 -> 8
    feed_row(3'b010, 32'd256, 32'd256, 1'b1);
    chk("basic_valid", 64'(out_valid), 64'(1));
    chk("basic_data",  64'(out_data),  64'(16'd8));
    chk("basic_last",  64'(out_last),  64'(0));

    // Rounding, including phase changes between compute states
    feed_row(3'b010, -32'sd48, -32'sd48, 1'b1);
    chk("rnd_m384", 64'(out_data), 64'(16'hFFFF));
    feed_row(3'b011, -32'sd48, -32'sd49, 1'b1);
    chk("rnd_m385", 64'(out_data), 64'(16'hFFFE));
    feed_row(3'b100, 32'd16, 32'd15, 1'b1);
    chk("rnd_127", 64'(out_data), 64'(16'h0000));
    feed_row(3'b010, 32'd16, 32'd16, 1'b1);
    chk("rnd_128", 64'(out_data), 64'(16'h0001));

    // Saturation, sticky flag, set beats clear
    feed_row(3'b010, 32'h7FFF0000, 32'h7FFF0000, 1'b1);
    chk("sat_pos_data", 64'(out_data), 64'(16'h7FFF));
    chk("sat_pos_flag", 64'(sat_flag), 64'(1));
    for (int i = 0; i < 7; i++) send(3'b011, 32'h80000000, 1'b1, 1'b0);
    send(3'b011, 32'h80000000, 1'b1, 1'b1);
    chk("sat_neg_data", 64'(out_data), 64'(16'h8000));
    chk("sat_set_wins", 64'(sat_flag), 64'(1));
    cycle(3'b010, 1'b0, 32'h0, 1'b1, 1'b1, a);
    chk("sat_cleared", 64'(sat_flag), 64'(0));
    idle(2, 3'b000, 1'b1);

    // Backpressure: two rows stored, third row stalls until release
    for (int i = 0; i < 16; i++) send(3'b010, rnd_p(), 1'b0, 1'b0);
    chk("bp_full_ready", 64'(p_ready), 64'(0));
    chk("bp_full_valid", 64'(out_valid), 64'(1));
    P = rnd_p();
    for (int i = 0; i < 3; i++) cycle(3'b011, 1'b1, P, 1'b0, 1'b0, a);
    chk("bp_stall_ready", 64'(p_ready), 64'(0));
    send(3'b011, P, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send(3'b100, rnd_p(), 1'b1, 1'b0);
    idle(4, 3'b010, 1'b1);

    // Framing: 512 products -> 64 samples, 8 row ends, one block end
    idle(1, 3'b000, 1'b1);
    n_pop_obs = 0; n_last_obs = 0; n_blk_obs = 0;
    for (int i = 0; i < 512; i++) begin
      if ($urandom % 4 == 0) cycle(rnd_st(), 1'b0, 32'h0, 1'b1, 1'b0, a);
      send(rnd_st(), rnd_p(), logic'($urandom % 4 != 0), 1'b0);
    end
    idle(10, 3'b010, 1'b1);
    chk("frame_pops",  64'(n_pop_obs),  64'(64));
    chk("frame_lasts", 64'(n_last_obs), 64'(8));
    chk("frame_blk",   64'(n_blk_obs),  64'(1));

    // Abort mid-row, then mid-row reset
    for (int i = 0; i < 5; i++) send(3'b010, 32'h00010000, 1'b1, 1'b0);
    cycle(3'b000, 1'b0, 32'h0, 1'b1, 1'b0, a);
    feed_row(3'b011, 32'd1, 32'd1, 1'b1);
    chk("abort_valid", 64'(out_valid), 64'(1));
    chk("abort_data",  64'(out_data),  64'(0));
    idle(2, 3'b011, 1'b1);
    for (int i = 0; i < 5; i++) send(3'b010, 32'h00010000, 1'b1, 1'b0);
    do_reset();
    feed_row(3'b011, 32'd1, 32'd1, 1'b1);
    chk("rst_mid_valid", 64'(out_valid), 64'(1));
    chk("rst_mid_data",  64'(out_data),  64'(0));

    // Randomised mix of phases, gaps, backpressure, aborts and clears
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom % 20);
      if (r == 0)
        cycle(3'b000, 1'b0, 32'h0, logic'($urandom % 2), 1'b0, a);
      else if (r < 4)
        cycle(rnd_st(), 1'b0, 32'h0, logic'($urandom % 2), logic'($urandom % 8 == 0), a);
      else
        send(rnd_st(), rnd_p(), logic'($urandom % 4 != 0), logic'($urandom % 10 == 0));
    end
    idle(6, 3'b010, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
